// File: rtl/mux_pkg.sv
// Shared types and helpers for the round-robin merge block.
// DATA_SIZE falls back to 32 when the build does not supply it.
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

package mux_pkg;

    localparam int DEFAULT_WIDTH = `DATA_SIZE;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority encoder: first requester at or after ptr wins.
// Purely combinational, reusable wherever a round-robin pick is needed.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int N     = 4,
    localparam int SEL_W = sel_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             enable,
    output logic [N-1:0]     grant,
    output logic [SEL_W-1:0] grant_idx
);

    int   w_j;
    logic w_found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_j       = 0;
        for (int k = 0; k < N; k++) begin
            w_j = int'(ptr) + k;
            if (w_j >= N) w_j = w_j - N;
            if (enable && !w_found && req[w_j]) begin
                grant[w_j] = 1'b1;
                grant_idx  = SEL_W'(w_j);
                w_found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_mux.sv
// N-way valid/ready merge with round-robin arbitration and one output register.
// RR_MUX_LOCK_EN adds in_last/out_last and holds the grant across a packet.
module rr_mux
    import mux_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int SEL_W = sel_width(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
`ifdef RR_MUX_LOCK_EN
    input  logic [N-1:0]       in_last,
    output logic               out_last,
`endif
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_sel,
    input  logic               out_ready
);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0] r_out_sel;
    logic [SEL_W-1:0] r_ptr;

    logic             w_load;
    logic [N-1:0]     w_req;
    logic [N-1:0]     w_grant;
    logic [SEL_W-1:0] w_idx;
    logic             w_xfer;
    logic             w_last;
    logic [WIDTH-1:0] w_data;
    logic [SEL_W-1:0] w_ptr_nxt;

    assign w_load = !r_out_valid || out_ready;

`ifdef RR_MUX_LOCK_EN
    logic             r_lock;
    logic [SEL_W-1:0] r_lock_ch;
    logic             r_out_last;

    // While locked only the owning channel may be considered.
    always_comb begin
        w_req = in_valid;
        if (r_lock) begin
            w_req = '0;
            for (int i = 0; i < N; i++) begin
                if (i == int'(r_lock_ch)) w_req[i] = in_valid[i];
            end
        end
    end

    assign w_last   = |(in_last & w_grant);
    assign out_last = r_out_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lock     <= 1'b0;
            r_lock_ch  <= '0;
            r_out_last <= 1'b0;
        end else if (w_xfer) begin
            r_lock     <= !w_last;
            r_lock_ch  <= w_idx;
            r_out_last <= w_last;
        end
    end
`else
    assign w_req  = in_valid;
    assign w_last = 1'b1;
`endif

    rr_arbiter #(
        .N(N)
    ) u_arb (
        .req      (w_req),
        .ptr      (r_ptr),
        .enable   (w_load && !reset),
        .grant    (w_grant),
        .grant_idx(w_idx)
    );

    assign in_ready = w_grant;
    assign w_xfer   = |w_grant;

    always_comb begin
        w_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant[i]) w_data = w_data | in_data[i*WIDTH +: WIDTH];
        end
    end

    assign w_ptr_nxt = (int'(w_idx) == N - 1) ? '0 : w_idx + SEL_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_ptr       <= '0;
        end else if (w_load) begin
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_data;
                r_out_sel   <= w_idx;
                if (w_last) r_ptr <= w_ptr_nxt;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule
